// File: rtl/vxe_vpu_agen_pkg.sv
// vxe_vpu_agen_pkg: shared FSM encoding and constants for the VPU vector address generators
package vxe_vpu_agen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } agen_state_e;

    localparam int MAX_LANES_LOG2 = 3;
    localparam int UNIT_STRIDE    = 1;

endpackage

// File: rtl/vxe_vpu_agen_beat.sv
// vxe_vpu_agen_beat: word count, word-enable mask and final-beat flag for the current beat
module vxe_vpu_agen_beat #(
    parameter int LANES_LOG2 = 1,
    parameter int LEN_W      = 20
) (
    input  logic [(LANES_LOG2 > 0 ? LANES_LOG2 : 1)-1:0] off,
    input  logic [LEN_W-1:0]                           vlen,
    input  logic                                       unit,
    output logic [LANES_LOG2:0]                        n,
    output logic [(1 << LANES_LOG2)-1:0]               mask,
    output logic                                       last
);

    localparam int WPB   = 1 << LANES_LOG2;
    localparam int CNT_W = LANES_LOG2 + 1;

    logic [CNT_W-1:0] room;

    // Unit stride fills the rest of the line (bounded by the remaining count); strided is one word
    always_comb begin
        room = CNT_W'(WPB) - CNT_W'(off);
        n    = !unit ? CNT_W'(1) : (vlen < LEN_W'(room)) ? CNT_W'(vlen) : room;
        mask = unit ? WPB'(((32'd1 << n) - 32'd1) << off) : WPB'(32'd1 << off);
        last = vlen == LEN_W'(n);
    end

endmodule

// File: rtl/vxe_vpu_vec_agen.sv
// vxe_vpu_vec_agen: vector address generator emitting line addresses and word masks over valid/ready
module vxe_vpu_vec_agen
    import vxe_vpu_agen_pkg::*;
#(
    parameter int ADDR_W     = 38,
    parameter int LEN_W      = 20,
    parameter int STRIDE_W   = 20,
    parameter int LANES_LOG2 = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [ADDR_W-1:0]            i_vaddr,
    input  logic [LEN_W-1:0]             i_vlen,
    input  logic [STRIDE_W-1:0]          i_stride,
    input  logic                         i_abort,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic [ADDR_W-LANES_LOG2-1:0] o_addr,
    output logic [(1 << LANES_LOG2)-1:0] o_we_mask,
    output logic [LANES_LOG2:0]          o_cnt,
    output logic                         o_last,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int WPB   = 1 << LANES_LOG2;
    localparam int OFF_W = LANES_LOG2 > 0 ? LANES_LOG2 : 1;
    localparam int CNT_W = LANES_LOG2 + 1;

    agen_state_e         state, state_nx;
    logic [ADDR_W-1:0]   q_vaddr, vaddr_nx, step;
    logic [LEN_W-1:0]    q_vlen, vlen_nx;
    logic [STRIDE_W-1:0] q_stride, stride_nx;
    logic                done_nx;
    logic [OFF_W-1:0]    off;
    logic                unit, last;
    logic [CNT_W-1:0]    n;
    logic [WPB-1:0]      mask;

    assign off  = q_vaddr[OFF_W-1:0] & OFF_W'(WPB - 1);
    assign unit = q_stride == STRIDE_W'(UNIT_STRIDE);
    assign step = unit ? ADDR_W'(n) : {{(ADDR_W-STRIDE_W){q_stride[STRIDE_W-1]}}, q_stride};

    vxe_vpu_agen_beat #(
        .LANES_LOG2(LANES_LOG2),
        .LEN_W     (LEN_W)
    ) u_beat (
        .off (off),
        .vlen(q_vlen),
        .unit(unit),
        .n   (n),
        .mask(mask),
        .last(last)
    );

    assign o_valid   = state == RUN;
    assign o_busy    = o_valid;
    assign o_addr    = q_vaddr[ADDR_W-1:LANES_LOG2];
    assign o_we_mask = o_valid ? mask : '0;
    assign o_cnt     = o_valid ? n : '0;
    assign o_last    = o_valid & last;

    // Next state: latch on start, abort beats a simultaneous transfer, advance on each accepted beat
    always_comb begin
        state_nx  = state;
        vaddr_nx  = q_vaddr;
        vlen_nx   = q_vlen;
        stride_nx = q_stride;
        done_nx   = 1'b0;
        if (state == IDLE) begin
            if (i_start && i_vlen != '0) begin
                state_nx  = RUN;
                vaddr_nx  = i_vaddr;
                vlen_nx   = i_vlen;
                stride_nx = i_stride;
            end
            done_nx = i_start && i_vlen == '0;
        end else if (i_abort) begin
            state_nx = IDLE;
        end else if (i_ready) begin
            vaddr_nx = q_vaddr + step;
            vlen_nx  = q_vlen - LEN_W'(n);
            state_nx = last ? IDLE : RUN;
            done_nx  = last;
        end
    end

    // State and operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            q_vaddr  <= '0;
            q_vlen   <= '0;
            q_stride <= '0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_nx;
            q_vaddr  <= vaddr_nx;
            q_vlen   <= vlen_nx;
            q_stride <= stride_nx;
            o_done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_vxe_vpu_vec_agen.sv
// tb_vxe_vpu_vec_agen: checks two-lane and four-lane generators against a word-list reference model
module tb_vxe_vpu_vec_agen;

    typedef struct packed {
        logic [37:0] addr;
        logic [7:0]  mask;
        logic [3:0]  cnt;
        logic        last;
    } beat_t;

    typedef struct {
        logic [37:0] va;
        int          vl;
        logic [19:0] st;
        int          nb0;
        int          nb1;
        logic [37:0] la0;
        logic [7:0]  fm0;
        logic [7:0]  fm1;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_start = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
    logic [37:0] i_vaddr = '0;
    logic [19:0] i_vlen = '0, i_stride = '0;

    logic        a_valid, a_last, a_busy, a_done;
    logic [36:0] a_addr;
    logic [1:0]  a_mask, a_cnt;
    logic        b_valid, b_last, b_busy, b_done;
    logic [35:0] b_addr;
    logic [3:0]  b_mask;
    logic [2:0]  b_cnt;

    int          checks = 0, failures = 0;
    bit          busy_m[2], done_m[2];
    int          beats_n[2];
    logic [37:0] last_addr[2];
    logic [7:0]  first_mask[2];
    beat_t       q0[$], q1[$];

    always #5 clk = ~clk;

    vxe_vpu_vec_agen #(.LANES_LOG2(1)) dut_a (
        .clk(clk), .rst(rst), .i_start(i_start), .i_vaddr(i_vaddr), .i_vlen(i_vlen),
        .i_stride(i_stride), .i_abort(i_abort), .i_ready(i_ready), .o_valid(a_valid),
        .o_addr(a_addr), .o_we_mask(a_mask), .o_cnt(a_cnt), .o_last(a_last),
        .o_busy(a_busy), .o_done(a_done)
    );

    vxe_vpu_vec_agen #(.LANES_LOG2(2)) dut_b (
        .clk(clk), .rst(rst), .i_start(i_start), .i_vaddr(i_vaddr), .i_vlen(i_vlen),
        .i_stride(i_stride), .i_abort(i_abort), .i_ready(i_ready), .o_valid(b_valid),
        .o_addr(b_addr), .o_we_mask(b_mask), .o_cnt(b_cnt), .o_last(b_last),
        .o_busy(b_busy), .o_done(b_done)
    );

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d act=%0h exp=%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic push(int d, beat_t b);
        b.cnt = 4'($countones(b.mask));
        if (d == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    // Reference: enumerate every element's word address, then group same-line words in unit mode
    task automatic gen(int d, logic [37:0] va, int vl, logic [19:0] st);
        int          ll = d == 0 ? 1 : 2;
        logic [37:0] a = va;
        logic [37:0] s = {{18{st[19]}}, st};
        bit          unit = st == 20'd1;
        bit          have = 0;
        beat_t       cur = '0;
        for (int i = 0; i < vl; i++) begin
            if (have && unit && (a >> ll) == cur.addr)
                cur.mask |= 8'(1) << int'(a % 38'(1 << ll));
            else begin
                if (have) push(d, cur);
                cur = '0;
                cur.addr = a >> ll;
                cur.mask = 8'(1) << int'(a % 38'(1 << ll));
                have = 1;
            end
            a = unit ? a + 38'd1 : a + s;
        end
        if (have) begin
            cur.last = 1'b1;
            push(d, cur);
        end
    endtask

    task automatic mon(int d, logic [37:0] ad, logic [7:0] mk, logic [3:0] ct,
                       logic v, logic l, logic bz, logic dn);
        beat_t f;
        chk("valid", d, 64'(v), 64'(busy_m[d]));
        chk("busy", d, 64'(bz), 64'(busy_m[d]));
        chk("done", d, 64'(dn), 64'(done_m[d]));
        done_m[d] = 0;
        if (busy_m[d]) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL model_underrun dut%0d valid with no expected beat", d);
                busy_m[d] = 0;
            end else begin
                f = d == 0 ? q0[0] : q1[0];
                chk("addr", d, 64'(ad), 64'(f.addr));
                chk("mask", d, 64'(mk), 64'(f.mask));
                chk("cnt", d, 64'(ct), 64'(f.cnt));
                chk("last", d, 64'(l), 64'(f.last));
                if (i_abort) begin
                    busy_m[d] = 0;
                    if (d == 0) q0.delete();
                    else q1.delete();
                end else if (i_ready) begin
                    if (d == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                    if (beats_n[d] == 0) first_mask[d] = f.mask;
                    beats_n[d]++;
                    if (f.last) begin
                        busy_m[d] = 0;
                        done_m[d] = 1;
                        last_addr[d] = f.addr;
                    end
                end
            end
        end else begin
            chk("idle_mask_cnt_last", d, 64'({mk, ct, l}), 64'd0);
            if (i_start) begin
                if (i_vlen == '0) done_m[d] = 1;
                else begin
                    busy_m[d] = 1;
                    gen(d, i_vaddr, int'(i_vlen), i_stride);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", 0, 64'({a_valid, a_addr, a_mask, a_cnt, a_last, a_busy, a_done}), 64'd0);
            chk("reset_outputs", 1, 64'({b_valid, b_addr, b_mask, b_cnt, b_last, b_busy, b_done}), 64'd0);
            busy_m = '{0, 0};
            done_m = '{0, 0};
            q0.delete();
            q1.delete();
        end else begin
            mon(0, 38'(a_addr), 8'(a_mask), 4'(a_cnt), a_valid, a_last, a_busy, a_done);
            mon(1, 38'(b_addr), 8'(b_mask), 4'(b_cnt), b_valid, b_last, b_busy, b_done);
        end
    end

    task automatic run_vec(logic [37:0] va, int vl, logic [19:0] st, int mode, int abort_at, int restart_at);
        beats_n = '{0, 0};
        @(posedge clk);
        #1;
        i_vaddr = va;
        i_vlen = 20'(vl);
        i_stride = st;
        i_start = 1'b1;
        i_ready = 1'b1;
        i_abort = 1'b0;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_vaddr = {6'($urandom), 32'($urandom)};
        i_vlen = 20'($urandom);
        i_stride = 20'($urandom);
        for (int c = 1; ; c++) begin
            if (!busy_m[0] && !busy_m[1]) break;
            if (c > 300) begin
                checks++;
                failures++;
                $display("FAIL timeout vector did not complete within 300 cycles");
                break;
            end
            i_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom) : 1'(c % 3 == 0);
            i_abort = c == abort_at;
            if (i_abort) i_ready = 1'b1;
            i_start = c == restart_at;
            if (i_start) i_vlen = 20'($urandom_range(1, 4));
            @(posedge clk);
            #1;
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        i_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{38'h100, 5, 20'd1,     3, 2, 38'h82,         8'b11, 8'b1111};
        tbl[1] = '{38'h103, 6, 20'd1,     4, 3, 38'h84,         8'b10, 8'b1000};
        tbl[2] = '{38'h10,  3, 20'hFFFFC, 3, 3, 38'h4,          8'b01, 8'b0001};
        tbl[3] = '{38'h2,   2, 20'hFFFFC, 2, 2, 38'h1FFFFFFFFF, 8'b01, 8'b0100};
        tbl[4] = '{38'h7,   3, 20'd0,     3, 3, 38'h3,          8'b10, 8'b1000};
        tbl[5] = '{38'h5,   1, 20'd1,     1, 1, 38'h2,          8'b10, 8'b0010};
        tbl[6] = '{38'h1,   3, 20'd1,     2, 1, 38'h1,          8'b10, 8'b1110};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i].va, tbl[i].vl, tbl[i].st, (i % 2) * 2, 0, 0);
            chk("tbl_beats", 0, 64'(beats_n[0]), 64'(tbl[i].nb0));
            chk("tbl_beats", 1, 64'(beats_n[1]), 64'(tbl[i].nb1));
            chk("tbl_last_addr", 0, 64'(last_addr[0]), 64'(tbl[i].la0));
            chk("tbl_first_mask", 0, 64'(first_mask[0]), 64'(tbl[i].fm0));
            chk("tbl_first_mask", 1, 64'(first_mask[1]), 64'(tbl[i].fm1));
        end

        run_vec(38'h40, 0, 20'd1, 0, 0, 0);
        chk("zero_len_beats", 0, 64'(beats_n[0]), 64'd0);

        run_vec(38'h300, 6, 20'd1, 0, 0, 2);
        chk("restart_ignored_beats", 0, 64'(beats_n[0]), 64'd3);
        chk("restart_ignored_addr", 0, 64'(last_addr[0]), 64'h182);

        run_vec(38'h200, 8, 20'd1, 0, 2, 0);
        chk("abort_beats", 0, 64'(beats_n[0]), 64'd1);
        run_vec(38'h20, 2, 20'd1, 0, 0, 0);
        chk("after_abort_beats", 0, 64'(beats_n[0]), 64'd1);

        @(posedge clk);
        #1;
        i_vaddr = 38'h500;
        i_vlen = 20'd9;
        i_stride = 20'd1;
        i_start = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 40; k++) begin
            logic [19:0] st;
            case ($urandom_range(0, 4))
                0: st = 20'd1;
                1: st = 20'd0;
                2: st = 20'hFFFFF;
                3: st = 20'd3;
                default: st = 20'($urandom);
            endcase
            run_vec({6'($urandom), 32'($urandom)}, int'($urandom_range(0, 9)), st, 1,
                    $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 5)) : 0,
                    $urandom_range(0, 5) == 0 ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vxe_vpu_vec_agen.md
Name: vxe_vpu_vec_agen

Overview:
Parametrised vector address generator for VPU execution units; successor to the fixed two-word product-unit address generator. Takes a word-granular base address, element count and signed stride. Emits a sequence of line addresses with per-word enable masks over a valid/ready handshake. Unit stride packs up to 2^LANES_LOG2 words per beat, honouring misalignment; any other stride emits one word per beat. Sits between the EU sequencer and the VPU memory request port.

Parameters:
ADDR_W, 38, word (32-bit) address width of i_vaddr
LEN_W, 20, element count width
STRIDE_W, 20, signed stride width in words, sign-extended to ADDR_W
LANES_LOG2, 1, log2 of words per beat (WPB = 2^LANES_LOG2); legal range 0..3

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_start  in  1  latch i_vaddr/i_vlen/i_stride; honoured only in IDLE
i_vaddr  in  ADDR_W  base word address
i_vlen  in  LEN_W  element count
i_stride  in  STRIDE_W  signed word stride
i_abort  in  1  cancel current vector
i_ready  in  1  consumer accepts the current beat
o_valid  out  1  beat valid
o_addr  out  ADDR_W-LANES_LOG2  line address = q_vaddr[ADDR_W-1:LANES_LOG2]
o_we_mask  out  WPB  word enables within line
o_cnt  out  LANES_LOG2+1  number of words in the beat (popcount of mask)
o_last  out  1  current beat is the final beat
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse on completion

Behaviour:
- States: IDLE, RUN. Reset: IDLE; q_vaddr=0; q_vlen=0; q_stride=0. Outputs at reset: o_valid=0, o_we_mask=0, o_cnt=0, o_last=0, o_busy=0, o_done=0, o_addr=0.
- IDLE & i_start & i_vlen!=0: latch operands, go RUN. First beat is valid in the next cycle.
- IDLE & i_start & i_vlen==0: stay IDLE; o_done=1 in the next cycle.
- i_start in RUN: ignored.
- Beat computation is combinational from registers. Let off = q_vaddr[LANES_LOG2-1:0].
  - Unit mode (q_stride==1): n = min(WPB-off, q_vlen); mask = ((1<<n)-1)<<off.
  - Strided mode (any other value, including 0 and negative): n=1; mask = 1<<off.
- Handshake: beat transfers when o_valid & i_ready. On transfer, q_vlen -= n.
  - q_vaddr += n in unit mode.
  - q_vaddr += sext(q_stride) in strided mode, modulo 2^ADDR_W (wraps silently).
- o_valid, o_addr, o_we_mask, o_cnt must stay stable while o_valid & !i_ready.
- o_last = o_valid & (q_vlen == n). A transfer with o_last set returns to IDLE; o_done=1 in the next cycle. Latency from the final handshake to o_done is 1 cycle.
- Stride 0: the same word is re-emitted q_vlen times.
- i_abort in RUN: go IDLE next cycle, o_valid=0, no o_done. Abort wins over a simultaneous transfer; that beat counts as not consumed by the generator, and the consumer must discard it. i_abort in IDLE has no effect.
- o_we_mask and o_cnt are forced to 0 when !o_valid.
- LANES_LOG2=1, unit stride: bit-compatible masks with the previous two-word generator (01/11/10 patterns).
- Reset asserted mid-vector: immediate return to reset values; no o_done.

Decomposition:
- Shared package vxe_vpu_agen_pkg: state encoding (IDLE/RUN), MAX_LANES_LOG2=3, and the unit-stride constant 1.
- One natural sub-module: vxe_vpu_agen_beat, a combinational block taking off, q_vlen and the mode bit and producing n, mask and last. It is reusable by the planned load/store EUs.
- The top module holds the FSM, operand registers and handshake.

Test Plan:
- LANES_LOG2=1; vaddr=0x100, vlen=5, stride=1, i_ready=1 -> beats addr 0x80/0x81/0x82, masks 11/11/01, o_last on the third beat, o_done one cycle later.
- LANES_LOG2=2; vaddr=0x103, vlen=6, stride=1 -> beat 1: addr 0x40 mask 1000 cnt 1; beat 2: addr 0x41 mask 1111 cnt 4; beat 3: addr 0x42 mask 0001 cnt 1.
- LANES_LOG2=1; vaddr=0x10, vlen=3, stride=-4 -> word addresses 0x10/0x0C/0x08, each mask 01; separately vaddr=0x2, vlen=2, stride=-4 -> second beat at word 0x3FFFFFFFFE (wrap).
- Backpressure: i_ready toggled 0,0,1 per beat -> outputs held stable while stalled; total beats and masks unchanged.
- i_abort asserted together with i_ready on beat 2 of 4 -> o_valid=0 next cycle, o_busy=0, no o_done; a new i_start is accepted in the following cycle.
- i_start with vlen=0 -> o_valid never asserts, o_done pulses once; i_start pulsed again during RUN -> ignored, operands unchanged.
